// File: rtl/result_packer.sv
// ============================================================================
//  Module   : result_packer (with calculator_pkg)
//  Brief    : Packs a stream of ALU results into memory-width words and
//             queues completed words in a small FIFO. A flush emits a
//             partially filled word with zeroed unused lanes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calculator_pkg;
   localparam int DATA_W        = 32;
   localparam int MEM_WORD_SIZE = 64;
endpackage

module result_packer
   import calculator_pkg::*;
#(
   parameter int LANE_W     = DATA_W,
   parameter int LANES      = MEM_WORD_SIZE / DATA_W,
   parameter int FIFO_DEPTH = 2,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [LANE_W-1:0]                result_i,
   input  logic                             result_valid_i,
   output logic                             result_ready_o,
   input  logic                             flush_i,
   output logic [LANES*LANE_W-1:0]          word_o,
   output logic [LANES-1:0]                 lane_mask_o,
   output logic                             word_valid_o,
   input  logic                             word_ready_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o
);

   localparam int c_PTR_W  = $clog2(LANES);
   localparam int c_FP_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int c_WORD_W = LANES * LANE_W;

   localparam logic [c_PTR_W-1:0] c_LAST_LANE = c_PTR_W'(LANES - 1);
   localparam logic [c_FP_W-1:0]  c_LAST_SLOT = c_FP_W'(FIFO_DEPTH - 1);
   localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);

   // Assembly state, kept in lane-index order; placement happens at push.
   logic [LANE_W-1:0]   r_lanes [LANES];
   logic [LANES-1:0]    r_mask;
   logic [c_PTR_W-1:0]  r_ptr;
   logic                r_hold;

   // Completed-word queue.
   logic [c_WORD_W-1:0] r_mem_word [FIFO_DEPTH];
   logic [LANES-1:0]    r_mem_mask [FIFO_DEPTH];
   logic [c_FP_W-1:0]   r_wr;
   logic [c_FP_W-1:0]   r_rd;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_not_full;
   logic                w_acc;
   logic                w_flush;
   logic                w_push;
   logic                w_pop;
   logic [LANE_W-1:0]   w_next_lanes [LANES];
   logic [LANES-1:0]    w_next_mask;
   logic [c_WORD_W-1:0] w_pack_word;

   assign w_not_full     = (r_count != c_FULL);
   assign result_ready_o = w_not_full;

   // r_hold masks the first edge after reset release so nothing is accepted
   // on it, while the ready output still reflects only the queue level.
   assign w_acc   = result_valid_i && w_not_full && !r_hold;
   assign w_flush = flush_i && w_not_full && !r_hold;

   // A word leaves the assembly when its last lane fills, or on a flush that
   // has at least one lane to carry (already written or arriving now).
   assign w_push = (w_acc && (r_ptr == c_LAST_LANE)) ||
                   (w_flush && (w_acc || (r_ptr != '0)));
   assign w_pop  = word_valid_o && word_ready_i;

   // Assembly contents as they would look after this cycle's accept.
   always_comb begin
      w_next_lanes = r_lanes;
      w_next_mask  = r_mask;
      if (w_acc) begin
         w_next_lanes[r_ptr] = result_i;
         w_next_mask[r_ptr]  = 1'b1;
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_pack
         if (LSB_FIRST) begin : g_lsb
            assign w_pack_word[i*LANE_W +: LANE_W] = w_next_lanes[i];
         end else begin : g_msb
            assign w_pack_word[(LANES-1-i)*LANE_W +: LANE_W] = w_next_lanes[i];
         end
      end
   endgenerate

   // Release-edge guard: set while reset is high, cleared on the next edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_hold <= 1'b1;
      else       r_hold <= 1'b0;
   end

   // Lane assembly: fill lane ptr, clear everything once the word is pushed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lanes <= '{default: '0};
         r_mask  <= '0;
         r_ptr   <= '0;
      end else if (w_push) begin
         r_lanes <= '{default: '0};
         r_mask  <= '0;
         r_ptr   <= '0;
      end else if (w_acc) begin
         r_lanes <= w_next_lanes;
         r_mask  <= w_next_mask;
         r_ptr   <= r_ptr + 1'b1;
      end
   end

   // Queue storage; visibility is controlled by the count, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_word[r_wr] <= w_pack_word;
         r_mem_mask[r_wr] <= w_next_mask;
      end
   end

   // Queue pointers and occupancy, wrapping modulo FIFO_DEPTH.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= (r_wr == c_LAST_SLOT) ? '0 : r_wr + 1'b1;
         if (w_pop)  r_rd <= (r_rd == c_LAST_SLOT) ? '0 : r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign word_valid_o = (r_count != '0);
   assign word_o       = word_valid_o ? r_mem_word[r_rd] : '0;
   assign lane_mask_o  = word_valid_o ? r_mem_mask[r_rd] : '0;
   assign count_o      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_result_packer.sv
// ============================================================================
//  Module   : tb_result_packer
//  Brief    : Self-checking bench for result_packer: directed scenarios on
//             three parameterisations plus a randomized run against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_packer;

   logic clk;
   logic rst;

   // Default instance: LANES=2, FIFO_DEPTH=2, LSB_FIRST=1
   logic [31:0]  res0;
   logic         rv0, fl0, wr0, rr0, wv0;
   logic [63:0]  w0;
   logic [1:0]   m0;
   logic [1:0]   c0;

   // LANES=4 instance
   logic [31:0]  res1;
   logic         rv1, fl1, wr1, rr1, wv1;
   logic [127:0] w1;
   logic [3:0]   m1;
   logic [1:0]   c1;

   // LSB_FIRST=0 instance
   logic [31:0]  res2;
   logic         rv2, fl2, wr2, rr2, wv2;
   logic [63:0]  w2;
   logic [1:0]   m2;
   logic [1:0]   c2;

   int cmp_cnt  = 0;
   int fail_cnt = 0;

   result_packer dut0 (
      .clk_i(clk), .rst_i(rst), .result_i(res0), .result_valid_i(rv0),
      .result_ready_o(rr0), .flush_i(fl0), .word_o(w0), .lane_mask_o(m0),
      .word_valid_o(wv0), .word_ready_i(wr0), .count_o(c0)
   );

   result_packer #(.LANES(4)) dut1 (
      .clk_i(clk), .rst_i(rst), .result_i(res1), .result_valid_i(rv1),
      .result_ready_o(rr1), .flush_i(fl1), .word_o(w1), .lane_mask_o(m1),
      .word_valid_o(wv1), .word_ready_i(wr1), .count_o(c1)
   );

   result_packer #(.LSB_FIRST(1'b0)) dut2 (
      .clk_i(clk), .rst_i(rst), .result_i(res2), .result_valid_i(rv2),
      .result_ready_o(rr2), .flush_i(fl2), .word_o(w2), .lane_mask_o(m2),
      .word_valid_o(wv2), .word_ready_i(wr2), .count_o(c2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      cmp_cnt++;
      assert (obs === exp)
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model for the default instance: results gathered per word,
   // completed words queued as plain numbers.
   localparam int M_LANES = 2;
   localparam int M_DEPTH = 2;
   int unsigned cur[$];
   logic [63:0] q_word[$];
   logic [1:0]  q_mask[$];

   task automatic model_emit();
      logic [63:0] w;
      logic [1:0]  m;
      w = '0;
      m = '0;
      foreach (cur[i]) begin
         w = w | (64'(cur[i]) << (32 * i));
         m[i] = 1'b1;
      end
      q_word.push_back(w);
      q_mask.push_back(m);
      cur.delete();
   endtask

   initial begin
      int nxt;
      bit acc, fls, pop, rdy;
      rst = 1'b1;
      res0 = '0; rv0 = 0; fl0 = 0; wr0 = 1;
      res1 = '0; rv1 = 0; fl1 = 0; wr1 = 1;
      res2 = '0; rv2 = 0; fl2 = 0; wr2 = 1;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 128'(wv0), 128'(1'b0));
      chk("rst_word",  128'(w0),  128'(64'h0));
      chk("rst_mask",  128'(m0),  128'(2'b00));
      chk("rst_count", 128'(c0),  128'(2'd0));
      chk("rst_ready", 128'(rr0), 128'(1'b1));
      rst = 1'b0;
      @(posedge clk);                       // release edge, idle inputs

      // ---------------- full word ----------------
      @(negedge clk); rv0 = 1; res0 = 32'h11111111;
      @(negedge clk); res0 = 32'h22222222;
      @(negedge clk); rv0 = 0;
      chk("full_valid", 128'(wv0), 128'(1'b1));
      chk("full_word",  128'(w0),  128'(64'h22222222_11111111));
      chk("full_mask",  128'(m0),  128'(2'b11));
      @(negedge clk);
      chk("full_valid_1cyc", 128'(wv0), 128'(1'b0));
      chk("full_count_0",    128'(c0),  128'(2'd0));

      // ---------------- flush partial, then flush at ptr 0 ----------------
      rv0 = 1; res0 = 32'hAAAAAAAA;
      @(negedge clk); rv0 = 0; fl0 = 1;
      @(negedge clk);
      chk("flush_valid", 128'(wv0), 128'(1'b1));
      chk("flush_word",  128'(w0),  128'(64'h00000000_AAAAAAAA));
      chk("flush_mask",  128'(m0),  128'(2'b01));
      @(negedge clk); fl0 = 0;
      chk("flush_empty_noop", 128'(wv0), 128'(1'b0));
      chk("flush_empty_cnt",  128'(c0),  128'(2'd0));

      // ---------------- backpressure ----------------
      wr0 = 0; nxt = 1;
      for (int k = 0; k < 6; k++) begin
         rv0 = 1; res0 = 32'(nxt);
         if (rr0) nxt++;
         @(negedge clk);
      end
      chk("bp_accepted", 128'(nxt - 1), 128'(4));
      chk("bp_count",    128'(c0),      128'(2'd2));
      chk("bp_ready",    128'(rr0),     128'(1'b0));
      chk("bp_word0",    128'(w0),      128'(64'h00000002_00000001));
      wr0 = 1; res0 = 32'd5;
      @(negedge clk);
      chk("bp_word1",    128'(w0),      128'(64'h00000004_00000003));
      chk("bp_ready_up", 128'(rr0),     128'(1'b1));
      @(negedge clk); res0 = 32'd6;
      @(negedge clk); rv0 = 0;
      chk("bp_word2",    128'(w0),      128'(64'h00000006_00000005));
      chk("bp_mask2",    128'(m0),      128'(2'b11));
      @(negedge clk);

      // ---------------- LANES=4 flush with result ----------------
      rv1 = 1; res1 = 32'hA;
      @(negedge clk); res1 = 32'hB; fl1 = 1;
      @(negedge clk); rv1 = 0; fl1 = 0;
      chk("l4_valid", 128'(wv1), 128'(1'b1));
      chk("l4_word",  w1,        128'h00000000_00000000_0000000B_0000000A);
      chk("l4_mask",  128'(m1),  128'(4'b0011));

      // ---------------- LSB_FIRST=0 ----------------
      rv2 = 1; res2 = 32'h1;
      @(negedge clk); res2 = 32'h2;
      @(negedge clk); rv2 = 0;
      chk("msb_word", 128'(w2), 128'(64'h00000001_00000002));
      chk("msb_mask", 128'(m2), 128'(2'b11));
      @(negedge clk);

      // ---------------- reset mid-word with a queued word ----------------
      wr0 = 0; rv0 = 1; res0 = 32'h7;
      @(negedge clk); res0 = 32'h8;
      @(negedge clk); res0 = 32'h5;
      @(negedge clk); rv0 = 1; res0 = 32'h99;
      chk("pre_rst_count", 128'(c0), 128'(2'd1));
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 128'(wv0), 128'(1'b0));
      chk("async_rst_word",  128'(w0),  128'(64'h0));
      chk("async_rst_count", 128'(c0),  128'(2'd0));
      chk("async_rst_ready", 128'(rr0), 128'(1'b1));
      @(negedge clk);
      rst = 1'b0;                            // 0x99 stays offered over the release edge
      @(negedge clk); res0 = 32'h1;
      @(negedge clk); res0 = 32'h2;
      @(negedge clk); rv0 = 0;
      chk("post_rst_word", 128'(w0), 128'(64'h00000002_00000001));
      chk("post_rst_mask", 128'(m0), 128'(2'b11));
      wr0 = 1;
      @(negedge clk);
      chk("post_rst_empty", 128'(wv0), 128'(1'b0));

      // ---------------- randomized run vs model ----------------
      for (int cyc = 0; cyc < 400; cyc++) begin
         chk("rnd_valid", 128'(wv0), 128'(q_word.size() != 0));
         chk("rnd_word",  128'(w0),  128'((q_word.size() != 0) ? q_word[0] : 64'h0));
         chk("rnd_mask",  128'(m0),  128'((q_mask.size() != 0) ? q_mask[0] : 2'b00));
         chk("rnd_count", 128'(c0),  128'(q_word.size()));
         chk("rnd_ready", 128'(rr0), 128'(q_word.size() != M_DEPTH));
         rv0  = ($urandom_range(0, 3) != 0);
         res0 = $urandom;
         fl0  = ($urandom_range(0, 7) == 0);
         wr0  = ($urandom_range(0, 2) != 0);
         rdy  = (q_word.size() != M_DEPTH);
         acc  = rv0 && rdy;
         fls  = fl0 && rdy;
         pop  = (q_word.size() != 0) && wr0;
         if (pop) begin
            void'(q_word.pop_front());
            void'(q_mask.pop_front());
         end
         if (acc) cur.push_back(res0);
         if (cur.size() == M_LANES || (fls && cur.size() != 0)) model_emit();
         @(negedge clk);
      end
      rv0 = 0; fl0 = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 SHALL import calculator_pkg; parameter LANE_W, default DATA_W, width of one ALU result.
REQ-002 SHALL have parameter LANES, default MEM_WORD_SIZE/DATA_W (2), results per packed word; legal range 2..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, completed-word queue entries; legal range 1..16.
REQ-004 SHALL have parameter LSB_FIRST, default 1; 1 = lane 0 at bits [LANE_W-1:0], 0 = lane 0 at the MSB lane.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Port list:
- clk_i  in  1  clock, posedge.
- rst_i  in  1  async active-high reset.
- result_i  in  LANE_W  ALU result.
- result_valid_i  in  1  result_i valid.
- result_ready_o  out  1  packer accepts result/flush this cycle.
- flush_i  in  1  emit the partial word.
- word_o  out  LANES*LANE_W  head-of-queue packed word.
- lane_mask_o  out  LANES  valid lanes of word_o, bit i = lane i.
- word_valid_o  out  1  queue non-empty.
- word_ready_i  in  1  consumer takes word_o.
- count_o  out  $clog2(FIFO_DEPTH+1)  queued words.

Function
REQ-007 SHALL hold an assembly register (LANES lanes), a lane pointer ptr (0..LANES-1) and a FIFO of {word, mask}, depth FIFO_DEPTH.
REQ-008 result_ready_o SHALL equal (count_o != FIFO_DEPTH); combinational, independent of word_ready_i.
REQ-009 Result accept = result_valid_i && result_ready_o; on accept result_i SHALL be written to lane ptr and that lane's mask bit set.
REQ-010 On accept with ptr==LANES-1, the completed word and mask all-ones SHALL be pushed; assembly cleared to zero; ptr <= 0.
REQ-011 On accept with ptr<LANES-1 and no flush, ptr SHALL increment; nothing pushed.
REQ-012 Flush accept = flush_i && result_ready_o; flush_i while result_ready_o=0 SHALL be ignored (source holds it).
REQ-013 Flush with simultaneous result accept SHALL include that result, then push the word with its partial mask; ptr <= 0.
REQ-014 Flush with ptr==0 and no result accept SHALL be a no-op (no empty word pushed).
REQ-015 Unwritten lanes of a pushed partial word SHALL be zero.
REQ-016 Pushed word SHALL appear on word_o/word_valid_o the cycle after the accepting edge (1-cycle latency, registered).
REQ-017 Pop = word_valid_o && word_ready_i; push and pop in the same cycle SHALL leave count_o unchanged and preserve order.
REQ-018 When word_valid_o=0, word_o and lane_mask_o SHALL be zero.
REQ-019 Words SHALL leave in strict push order; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-020 No accepted result SHALL ever be dropped or duplicated.

Reset
REQ-021 On rst_i assertion, immediately and independent of clk_i: ptr=0, assembly=0, FIFO empty, word_o=0, lane_mask_o=0, word_valid_o=0, count_o=0, result_ready_o=1.
REQ-022 Reset mid-word SHALL discard the partial word and all queued words; the first accept after release SHALL go to lane 0.
REQ-023 Deassertion SHALL be synchronised to clk_i so no accept occurs on the release edge.

Verification
REQ-024 Defaults, word_ready_i=1: accept 0x11111111 then 0x22222222 -> next cycle word_o=0x22222222_11111111, lane_mask_o=2'b11, word_valid_o for 1 cycle.
REQ-025 Defaults: accept 0xAAAAAAAA, then flush_i alone -> word_o=0x00000000_AAAAAAAA, mask=2'b01; second flush at ptr=0 -> nothing pushed.
REQ-026 Defaults, word_ready_i=0, 6 results offered back-to-back -> 4 accepted, count_o=2, result_ready_o=0; raise word_ready_i -> 2 words in order, remaining 2 results then accepted.
REQ-027 LANES=4: accept 0xA, then 0xB with flush_i same cycle -> word_o=0x00000000_00000000_0000000B_0000000A, mask=4'b0011.
REQ-028 Defaults: accept 0x5, assert rst_i between edges -> outputs zero within that cycle; after release accept 0x1, 0x2 -> word 0x00000002_00000001 (0x5 gone).
REQ-029 LSB_FIRST=0: accept 0x1 then 0x2 -> word_o=0x00000001_00000002, mask=2'b11.
